// File: rtl/exp_arbiter_if.sv
// rtl/exp_arbiter_if.sv - exception source / CP0 handshake bundle for exp_arbiter
interface exp_arbiter_if #(
  parameter int NSRC = 3,
  parameter int IDW  = 3
) ();
  logic [NSRC-1:0] irq_in;
  logic [NSRC-1:0] mask;
  logic            exp_block;
  logic            exp_taken;
  logic            is_eret;
  logic [NSRC-1:0] exp_src;
  logic [IDW-1:0]  cur_id;
  logic            busy;
  logic [NSRC-1:0] pending;

  // Sources and CP0 side: drives requests and control, observes the arbiter.
  modport master (
    output irq_in, mask, exp_block, exp_taken, is_eret,
    input  exp_src, cur_id, busy, pending
  );

  // Arbiter side.
  modport slave (
    input  irq_in, mask, exp_block, exp_taken, is_eret,
    output exp_src, cur_id, busy, pending
  );
endinterface

// File: rtl/exp_arbiter.sv
// rtl/exp_arbiter.sv - exception request arbiter feeding CP0 ExpSrc (optional EXP_ARB_ROUNDROBIN_EN)
module exp_arbiter #(
  parameter int NSRC = 3,
  parameter int IDW  = 3
) (
  input  logic          clk,
  input  logic          reset,
  exp_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    SERVICE = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [NSRC-1:0] pending_q, pending_d;
  logic [NSRC-1:0] exp_src_q, exp_src_d;
  logic [IDW-1:0]  cur_id_q, cur_id_d;
  logic [NSRC-1:0] eligible;
  logic [NSRC-1:0] clr;
  logic [NSRC-1:0] cur_sel;
  logic [IDW-1:0]  winner;
  logic            grant;
`ifdef EXP_ARB_ROUNDROBIN_EN
  logic [IDW-1:0]  rr_q, rr_d;
  logic [IDW-1:0]  cand;
`endif

  // One-hot decode built by comparison so index widths never mismatch.
  function automatic logic [NSRC-1:0] onehot(input logic [IDW-1:0] id);
    logic [NSRC-1:0] v;
    for (int i = 0; i < NSRC; i++) v[i] = (id == IDW'(i));
    return v;
  endfunction

  // Eligibility and winner selection.
  always_comb begin
    eligible = bus.pending & ~bus.mask;
    winner   = '0;
`ifdef EXP_ARB_ROUNDROBIN_EN
    cand     = '0;
    for (int k = NSRC - 1; k >= 0; k--) begin
      cand = IDW'((int'(rr_q) + k) % NSRC);
      if ((eligible & onehot(cand)) != '0) winner = cand;
    end
`else
    for (int i = NSRC - 1; i >= 0; i--) begin
      if ((eligible & onehot(IDW'(i))) != '0) winner = IDW'(i);
    end
`endif
    grant = (eligible != '0) && !bus.exp_block;
  end

  // Next-state, output and pending-clear logic.
  always_comb begin
    state_d   = state_q;
    exp_src_d = exp_src_q;
    cur_id_d  = cur_id_q;
    clr       = '0;
    cur_sel   = onehot(cur_id_q);
`ifdef EXP_ARB_ROUNDROBIN_EN
    rr_d      = rr_q;
`endif
    case (state_q)
      IDLE: begin
        exp_src_d = '0;
        if (grant) begin
          state_d   = REQ;
          exp_src_d = onehot(winner);
          cur_id_d  = winner;
        end
      end
      REQ: begin
        // Acceptance beats withdrawal when both happen in the same cycle.
        if (bus.exp_taken) begin
          state_d   = SERVICE;
          exp_src_d = '0;
          clr       = cur_sel;
`ifdef EXP_ARB_ROUNDROBIN_EN
          rr_d      = (cur_id_q == IDW'(NSRC - 1)) ? '0 : cur_id_q + 1'b1;
`endif
        end else if (((bus.mask & cur_sel) != '0) || bus.exp_block) begin
          state_d   = IDLE;
          exp_src_d = '0;
        end
      end
      SERVICE: begin
        exp_src_d = '0;
        if (bus.is_eret) state_d = IDLE;
      end
      default: begin
        state_d   = IDLE;
        exp_src_d = '0;
      end
    endcase
    // A new event wins over a same-cycle clear so it is never lost.
    pending_d = (pending_q & ~clr) | bus.irq_in;
  end

  // State and output registers with asynchronous reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      pending_q <= '0;
      exp_src_q <= '0;
      cur_id_q  <= '0;
`ifdef EXP_ARB_ROUNDROBIN_EN
      rr_q      <= '0;
`endif
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      exp_src_q <= exp_src_d;
      cur_id_q  <= cur_id_d;
`ifdef EXP_ARB_ROUNDROBIN_EN
      rr_q      <= rr_d;
`endif
    end
  end

  assign bus.exp_src = exp_src_q;
  assign bus.cur_id  = cur_id_q;
  assign bus.busy    = (state_q != IDLE);
  assign bus.pending = pending_q;

endmodule
